// File: rtl/wbgpio_irq_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wbgpio_irq_if : Wishbone B4 pipelined slave bundle for wbgpio_irq  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface wbgpio_irq_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  wb_cyc_i;
    logic                  wb_stb_i;
    logic                  wb_we_i;
    logic [ADDR_WIDTH-1:0] wb_adr_i;
    logic [3:0]            wb_sel_i;
    logic [DATA_WIDTH-1:0] wb_dat_i;
    logic [DATA_WIDTH-1:0] wb_dat_o;
    logic                  wb_ack_o;
    logic                  wb_stall_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_stall_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_stall_o
    );
endinterface
`default_nettype wire

// File: rtl/wbgpio_irq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wbgpio_irq : Wishbone GPIO with direction, toggle and edge/level   |
// |              interrupts with W1C status                            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module wbgpio_irq #(
    parameter int GPIO_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int SYNC_STAGES = 2
) (
    input  wire                   clk,
    input  wire                   rst,
    wbgpio_irq_if.slave           wb,
    input  wire  [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq_o
);
    localparam logic [2:0] c_ADDR_IN     = 3'd0;
    localparam logic [2:0] c_ADDR_OUT    = 3'd1;
    localparam logic [2:0] c_ADDR_DIR    = 3'd2;
    localparam logic [2:0] c_ADDR_IRQEN  = 3'd3;
    localparam logic [2:0] c_ADDR_TYPE   = 3'd4;
    localparam logic [2:0] c_ADDR_POL    = 3'd5;
    localparam logic [2:0] c_ADDR_STATUS = 3'd6;
    localparam logic [2:0] c_ADDR_TGL    = 3'd7;
    localparam logic [2:0] c_WARM_DONE   = 3'(SYNC_STAGES + 1);

    logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_WIDTH-1:0] prev_q;
    logic [2:0]            warm_q;
    logic [GPIO_WIDTH-1:0] out_q, out_d, dir_q, dir_d, en_q, en_d;
    logic [GPIO_WIDTH-1:0] type_q, type_d, pol_q, pol_d, status_q, status_d;
    logic                  ack_q, irq_q;
    logic [DATA_WIDTH-1:0] dat_q;

    logic                  acc, wr;
    logic [2:0]            word;
    logic [DATA_WIDTH-1:0] wmask, rdata;
    logic [GPIO_WIDTH-1:0] rdata_g, wdat, wm, s, edge_ev, lvl_ev, ev;
    logic                  edge_en;
    logic                  w_unused;

    assign acc     = wb.wb_cyc_i & wb.wb_stb_i;
    assign wr      = acc & wb.wb_we_i;
    assign word    = wb.wb_adr_i[ADDR_WIDTH-1:2];
    assign s       = sync_q[SYNC_STAGES-1];
    assign edge_en = (warm_q == c_WARM_DONE);
    assign wdat    = wb.wb_dat_i[GPIO_WIDTH-1:0];
    assign wm      = wmask[GPIO_WIDTH-1:0];
    assign w_unused = ^{1'b0, wb.wb_adr_i[1:0]};

    always_comb begin
        wmask = '0;
        for (int b = 0; b < 4; b++) begin
            wmask[8*b +: 8] = {8{wb.wb_sel_i[b]}};
        end
    end

    // Warm-up gating keeps the zeroed sync chain from faking edges after reset.
    assign edge_ev = (pol_q & s & ~prev_q) | (~pol_q & ~s & prev_q);
    assign lvl_ev  = (pol_q & s) | (~pol_q & ~s);
    assign ev      = (type_q & edge_ev & {GPIO_WIDTH{edge_en}}) | (~type_q & lvl_ev);

    always_comb begin
        rdata_g = '0;
        case (word)
            c_ADDR_IN:     rdata_g = s;
            c_ADDR_OUT:    rdata_g = out_q;
            c_ADDR_DIR:    rdata_g = dir_q;
            c_ADDR_IRQEN:  rdata_g = en_q;
            c_ADDR_TYPE:   rdata_g = type_q;
            c_ADDR_POL:    rdata_g = pol_q;
            c_ADDR_STATUS: rdata_g = status_q;
            default:       rdata_g = '0;
        endcase
        rdata = '0;
        rdata[GPIO_WIDTH-1:0] = rdata_g;
    end

    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        en_d     = en_q;
        type_d   = type_q;
        pol_d    = pol_q;
        status_d = status_q;
        if (wr) begin
            case (word)
                c_ADDR_OUT:    out_d    = (out_q  & ~wm) | (wdat & wm);
                c_ADDR_DIR:    dir_d    = (dir_q  & ~wm) | (wdat & wm);
                c_ADDR_IRQEN:  en_d     = (en_q   & ~wm) | (wdat & wm);
                c_ADDR_TYPE:   type_d   = (type_q & ~wm) | (wdat & wm);
                c_ADDR_POL:    pol_d    = (pol_q  & ~wm) | (wdat & wm);
                c_ADDR_STATUS: status_d = status_q & ~(wdat & wm);
                c_ADDR_TGL:    out_d    = out_q ^ (wdat & wm);
                default:       ;
            endcase
        end
        // A new event overrides a same-cycle clear.
        status_d = status_d | ev;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q   <= '0;
            warm_q   <= '0;
            out_q    <= '0;
            dir_q    <= '0;
            en_q     <= '0;
            type_q   <= '0;
            pol_q    <= '0;
            status_q <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= s;
            if (warm_q != c_WARM_DONE) begin
                warm_q <= warm_q + 3'd1;
            end
            out_q    <= out_d;
            dir_q    <= dir_d;
            en_q     <= en_d;
            type_q   <= type_d;
            pol_q    <= pol_d;
            status_q <= status_d;
            ack_q    <= acc;
            if (acc) begin
                dat_q <= rdata;
            end
            irq_q <= |(status_q & en_q);
        end
    end

    assign wb.wb_ack_o   = ack_q;
    assign wb.wb_dat_o   = dat_q;
    assign wb.wb_stall_o = 1'b0;
    assign gpio_o        = out_q;
    assign gpio_oe       = dir_q;
    assign irq_o         = irq_q;
endmodule
`default_nettype wire

// File: tb/tb_wbgpio_irq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_wbgpio_irq : randomized bench for wbgpio_irq with a register-  |
// |                 level reference model                             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_wbgpio_irq;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpio_i;
    logic [31:0] gpio_o, gpio_oe;
    logic        irq_o;
    int          n_chk = 0;
    int          n_err = 0;

    wbgpio_irq_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    wbgpio_irq #(
        .GPIO_WIDTH(32), .DATA_WIDTH(32), .ADDR_WIDTH(5), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst(rst), .wb(bus), .gpio_i(gpio_i),
        .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (register-level view) ----------------
    logic [31:0] m_out, m_dir, m_en, m_typ, m_pol, m_sts, m_dat;
    logic        m_ack, m_irq, m_rdv;
    logic [31:0] hist[$];
    int          n_edges;

    function automatic logic [31:0] pins_ago(int k);
        if (hist.size() > k) return hist[k];
        return 32'h0;
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] s, p, ev, rd, wm, wd;
        logic        acc, irq_n;
        if (rst) begin
            {m_out, m_dir, m_en, m_typ, m_pol, m_sts, m_dat} = '0;
            m_ack = 1'b0; m_irq = 1'b0; m_rdv = 1'b0;
            hist.delete();
            n_edges = 0;
        end else begin
            s = pins_ago(SYNC - 1);
            p = pins_ago(SYNC);
            for (int i = 0; i < 32; i++) begin
                if (m_typ[i])
                    ev[i] = (n_edges > SYNC) && (m_pol[i] ? (s[i] && !p[i]) : (!s[i] && p[i]));
                else
                    ev[i] = (s[i] == m_pol[i]);
            end
            case (bus.wb_adr_i[4:2])
                3'd0: rd = s;
                3'd1: rd = m_out;
                3'd2: rd = m_dir;
                3'd3: rd = m_en;
                3'd4: rd = m_typ;
                3'd5: rd = m_pol;
                3'd6: rd = m_sts;
                default: rd = 32'h0;
            endcase
            irq_n = |(m_sts & m_en);
            acc = bus.wb_cyc_i && bus.wb_stb_i;
            for (int b = 0; b < 4; b++) wm[8*b +: 8] = {8{bus.wb_sel_i[b]}};
            wd = bus.wb_dat_i & wm;
            if (acc && bus.wb_we_i) begin
                case (bus.wb_adr_i[4:2])
                    3'd1: m_out = (m_out & ~wm) | wd;
                    3'd2: m_dir = (m_dir & ~wm) | wd;
                    3'd3: m_en  = (m_en  & ~wm) | wd;
                    3'd4: m_typ = (m_typ & ~wm) | wd;
                    3'd5: m_pol = (m_pol & ~wm) | wd;
                    3'd6: m_sts = m_sts & ~wd;
                    3'd7: m_out = m_out ^ wd;
                    default: ;
                endcase
            end
            m_sts = m_sts | ev;
            m_ack = acc;
            m_rdv = acc && !bus.wb_we_i;
            if (m_rdv) m_dat = rd;
            m_irq = irq_n;
            hist.push_front(gpio_i);
            if (hist.size() > SYNC + 1) void'(hist.pop_back());
            if (n_edges < 1000) n_edges++;
        end
    end

    // Outputs are compared against the model every cycle, away from the edge.
    always @(negedge clk) begin
        chk_eq("ack", {31'h0, bus.wb_ack_o}, {31'h0, m_ack});
        if (m_rdv) chk_eq("rdata", bus.wb_dat_o, m_dat);
        chk_eq("stall", {31'h0, bus.wb_stall_o}, 32'h0);
        chk_eq("gpio_o", gpio_o, m_out);
        chk_eq("gpio_oe", gpio_oe, m_dir);
        chk_eq("irq", {31'h0, irq_o}, {31'h0, m_irq});
    end

    // ---------------- bus helpers (called at a negedge) ----------------
    task automatic bus_idle();
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = '0; bus.wb_sel_i = '0; bus.wb_dat_i = '0;
    endtask

    task automatic wb_xfer(input logic we, input logic [4:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, output logic [31:0] rdat);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
        bus.wb_adr_i = adr; bus.wb_sel_i = sel; bus.wb_dat_i = dat;
        @(negedge clk);
        rdat = bus.wb_dat_o;
        bus_idle();
    endtask

    task automatic wb_write(input logic [4:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        logic [31:0] unused_rd;
        wb_xfer(1'b1, adr, sel, dat, unused_rd);
    endtask

    task automatic wb_read(input logic [4:0] adr, output logic [31:0] rdat);
        wb_xfer(1'b0, adr, 4'hF, 32'h0, rdat);
    endtask

    initial begin
        logic [31:0] rd;
        int          lat, acks;
        rst = 1'b1;
        gpio_i = 32'hFFFF_FFF7;
        bus_idle();
        repeat (3) @(negedge clk);
        chk_eq("rst_ack", {31'h0, bus.wb_ack_o}, 32'h0);
        chk_eq("rst_dat", bus.wb_dat_o, 32'h0);
        chk_eq("rst_oe", gpio_oe, 32'h0);
        chk_eq("rst_irq", {31'h0, irq_o}, 32'h0);
        rst = 1'b0;

        // T1: configuration registers and toggle read 0 after reset
        for (int a = 1; a < 8; a++) begin
            if (a != 6) begin
                wb_read(5'(a * 4), rd);
                chk_eq($sformatf("t1_reg%0d", a), rd, 32'h0);
            end
        end

        // T2: byte-selected write and atomic toggle
        wb_write(5'h08, 4'hF, 32'h0000_FFFF);
        wb_write(5'h04, 4'b0011, 32'hA5A5_A5A5);
        chk_eq("t2_out", gpio_o, 32'h0000_A5A5);
        chk_eq("t2_oe", gpio_oe, 32'h0000_FFFF);
        wb_write(5'h1C, 4'hF, 32'h0000_000F);
        chk_eq("t2_tgl", gpio_o, 32'h0000_A5AA);

        // T3: rising edge on pin 3, latency and W1C
        wb_write(5'h10, 4'hF, 32'h8);
        wb_write(5'h14, 4'hF, 32'h8);
        wb_write(5'h0C, 4'hF, 32'h8);
        wb_write(5'h18, 4'hF, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        chk_eq("t3_idle_irq", {31'h0, irq_o}, 32'h0);
        gpio_i[3] = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (irq_o && lat == 0) lat = k;
        end
        chk_eq("t3_irq_lat", 32'(lat), 32'd4);
        wb_read(5'h18, rd);
        chk_eq("t3_sts3", {31'h0, rd[3]}, 32'h1);
        wb_write(5'h18, 4'hF, 32'h8);
        repeat (2) @(negedge clk);
        chk_eq("t3_clr_irq", {31'h0, irq_o}, 32'h0);

        // T4: level-low pin 5 re-sets after clear while held
        gpio_i[5] = 1'b0;
        repeat (5) @(negedge clk);
        wb_write(5'h18, 4'hF, 32'h20);
        wb_read(5'h18, rd);
        chk_eq("t4_held", {31'h0, rd[5]}, 32'h1);
        gpio_i[5] = 1'b1;
        repeat (5) @(negedge clk);
        wb_write(5'h18, 4'hF, 32'h20);
        wb_read(5'h18, rd);
        chk_eq("t4_released", {31'h0, rd[5]}, 32'h0);

        // T5: event and clear in the same cycle, set wins
        wb_write(5'h10, 4'hF, 32'h9);
        wb_write(5'h14, 4'hF, 32'h9);
        gpio_i[0] = 1'b0;
        repeat (5) @(negedge clk);
        wb_write(5'h18, 4'hF, 32'h1);
        repeat (2) @(negedge clk);
        gpio_i[0] = 1'b1;
        repeat (2) @(negedge clk);
        wb_write(5'h18, 4'hF, 32'h1);
        wb_read(5'h18, rd);
        chk_eq("t5_set_wins", {31'h0, rd[0]}, 32'h1);

        // Randomized traffic checked cycle by cycle against the model
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 3) == 0) gpio_i = gpio_i ^ (32'h1 << $urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: @(negedge clk);
                1: wb_read(5'($urandom_range(0, 7) * 4), rd);
                default: wb_write(5'($urandom_range(0, 7) * 4), 4'($urandom_range(0, 15)),
                                  ($urandom_range(0, 1) == 1) ? $urandom : (32'h1 << $urandom_range(0, 31)));
            endcase
        end
        repeat (4) @(negedge clk);

        // T6: back-to-back reads, then reset in the middle of a burst
        acks = 0;
        for (int a = 1; a <= 4; a++) begin
            wb_read(5'(a * 4), rd);
            if (bus.wb_ack_o) acks++;
        end
        chk_eq("t6_b2b_acks", 32'(acks), 32'd4);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = 5'h04; bus.wb_sel_i = 4'hF;
        repeat (2) @(negedge clk);
        chk_eq("t6_burst_ack", {31'h0, bus.wb_ack_o}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk_eq("t6_rst_ack", {31'h0, bus.wb_ack_o}, 32'h0);
        bus_idle();
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
